// File: rtl/contador_transiciones_multicanal_pkg.sv
// contador_transiciones_multicanal_pkg: shared defaults, read FSM encoding and adder channel map
//   NUM_CH_DEF/SIG_W_DEF/CNT_W_DEF/DIR_W_DEF : default sizing of the counter bank
//   estado_t                                 : read FSM states (IDLE=0, VALID=1)
//   RIZADO/LOGICO/LOOKAHEAD                  : channel index of each monitored adder
package contador_transiciones_multicanal_pkg;
    localparam int NUM_CH_DEF = 3;
    localparam int SIG_W_DEF  = 8;
    localparam int CNT_W_DEF  = 32;
    localparam int DIR_W_DEF  = 2;
    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } estado_t;
    localparam int RIZADO    = 0;
    localparam int LOGICO    = 1;
    localparam int LOOKAHEAD = 2;
endpackage

// File: rtl/contador_transiciones_multicanal_if.sv
// contador_transiciones_multicanal_if: monitored buses, count control and read handshake bundle
//   en, sig_in, clr               : counting inputs (master -> slave)
//   rd_req, rd_dir, rd_ack        : read request / channel / accept (master -> slave)
//   rd_valid, rd_dato, rd_ovf,
//   rd_err, busy                  : read response (slave -> master)
interface contador_transiciones_multicanal_if
    import contador_transiciones_multicanal_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int SIG_W  = SIG_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int DIR_W  = DIR_W_DEF
);
    logic                    en;
    logic [NUM_CH*SIG_W-1:0] sig_in;
    logic                    clr;
    logic                    rd_req;
    logic [DIR_W-1:0]        rd_dir;
    logic                    rd_ack;
    logic                    rd_valid;
    logic [CNT_W-1:0]        rd_dato;
    logic                    rd_ovf;
    logic                    rd_err;
    logic                    busy;
    modport master (
        output en, sig_in, clr, rd_req, rd_dir, rd_ack,
        input  rd_valid, rd_dato, rd_ovf, rd_err, busy
    );
    modport slave (
        input  en, sig_in, clr, rd_req, rd_dir, rd_ack,
        output rd_valid, rd_dato, rd_ovf, rd_err, busy
    );
endinterface

// File: rtl/contador_transiciones_multicanal_unos.sv
// contador_unos: combinational popcount of a W-bit vector
//   i_vec : input vector
//   o_cnt : number of ones in i_vec (0..W)
module contador_unos #(
    parameter int W = 8
)(
    input  logic [W-1:0]           i_vec,
    output logic [$clog2(W+1)-1:0] o_cnt
);
    localparam int OW = $clog2(W + 1);
    always_comb begin
        o_cnt = '0;
        for (int i = 0; i < W; i++) o_cnt = o_cnt + OW'(i_vec[i]);
    end
endmodule

// File: rtl/contador_transiciones_multicanal.sv
// contador_transiciones_multicanal: per-channel saturating toggle counters with handshake readback
//   clk     : rising-edge clock
//   reset_L : asynchronous active-low reset
//   bus     : slave side of the counting/read interface
module contador_transiciones_multicanal
    import contador_transiciones_multicanal_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int SIG_W  = SIG_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int DIR_W  = DIR_W_DEF
)(
    input logic                               clk,
    input logic                               reset_L,
    contador_transiciones_multicanal_if.slave bus
);
    localparam int POP_W = $clog2(SIG_W + 1);
    localparam int N_DIR = 2 ** DIR_W;

    logic [SIG_W-1:0] r_prev   [NUM_CH];
    logic [CNT_W-1:0] r_cnt    [NUM_CH];
    logic [NUM_CH-1:0] r_ovf;
    logic [NUM_CH-1:0] r_primed;
    logic [POP_W-1:0] w_pop    [NUM_CH];
    logic [CNT_W:0]   w_suma   [NUM_CH];

    genvar k;
    generate
        for (k = 0; k < NUM_CH; k++) begin : g_canal
            contador_unos #(.W(SIG_W)) u_pop (
                .i_vec (bus.sig_in[k*SIG_W +: SIG_W] ^ r_prev[k]),
                .o_cnt (w_pop[k])
            );
        end
    endgenerate

    // One extra carry bit so saturation is detected from the sum itself
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) w_suma[i] = {1'b0, r_cnt[i]} + (CNT_W+1)'(w_pop[i]);
    end

    // prev always tracks the bus; the first edge after reset/clr only primes it
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_prev[i] <= '0;
                r_cnt[i]  <= '0;
            end
            r_ovf    <= '0;
            r_primed <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_prev[i] <= bus.sig_in[i*SIG_W +: SIG_W];
                if (bus.clr) begin
                    r_cnt[i]    <= '0;
                    r_ovf[i]    <= 1'b0;
                    r_primed[i] <= 1'b0;
                end else begin
                    r_primed[i] <= 1'b1;
                    if (r_primed[i] && bus.en) begin
                        r_cnt[i] <= w_suma[i][CNT_W] ? '1 : w_suma[i][CNT_W-1:0];
                        if (w_suma[i][CNT_W]) r_ovf[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Read address space padded to 2^DIR_W; unused slots read as zero
    logic [CNT_W-1:0] w_cnt_dir [N_DIR];
    logic [N_DIR-1:0] w_ovf_dir;
    logic             w_err;
    always_comb begin
        w_ovf_dir = '0;
        for (int i = 0; i < N_DIR; i++) w_cnt_dir[i] = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_cnt_dir[i] = r_cnt[i];
            w_ovf_dir[i] = r_ovf[i];
        end
        w_err = int'(bus.rd_dir) >= NUM_CH;
    end

    estado_t          r_estado;
    estado_t          w_estado_sig;
    logic             w_carga;
    logic [CNT_W-1:0] r_dato;
    logic             r_ovf_rd;
    logic             r_err;

    always_comb begin
        w_estado_sig = r_estado;
        w_carga      = 1'b0;
        if (r_estado == IDLE) begin
            w_carga      = bus.rd_req;
            w_estado_sig = bus.rd_req ? VALID : IDLE;
        end else begin
            w_estado_sig = bus.rd_ack ? IDLE : VALID;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_estado <= IDLE;
            r_dato   <= '0;
            r_ovf_rd <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_estado <= w_estado_sig;
            if (w_carga) begin
                r_dato   <= w_cnt_dir[bus.rd_dir];
                r_ovf_rd <= w_ovf_dir[bus.rd_dir];
                r_err    <= w_err;
            end
        end
    end

    assign bus.rd_valid = (r_estado == VALID);
    assign bus.busy     = (r_estado == VALID);
    assign bus.rd_dato  = r_dato;
    assign bus.rd_ovf   = r_ovf_rd;
    assign bus.rd_err   = r_err;
endmodule

// File: tb/tb_contador_transiciones_multicanal.sv
// tb_contador_transiciones_multicanal: directed table-driven bench for the toggle counter bank
module tb_contador_transiciones_multicanal;
    logic clk;
    logic reset_L;
    int   checks = 0;
    int   errors = 0;

    contador_transiciones_multicanal_if #(.NUM_CH(3), .SIG_W(8), .CNT_W(32), .DIR_W(2)) bus ();
    contador_transiciones_multicanal_if #(.NUM_CH(3), .SIG_W(8), .CNT_W(4), .DIR_W(2)) bus4 ();

    contador_transiciones_multicanal #(.NUM_CH(3), .SIG_W(8), .CNT_W(32), .DIR_W(2)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );
    contador_transiciones_multicanal #(.NUM_CH(3), .SIG_W(8), .CNT_W(4), .DIR_W(2)) dut4 (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        int          ch;
        logic [7:0]  a;
        logic [7:0]  b;
        int          n;
        logic        en;
        logic [1:0]  rd;
        logic [31:0] e_dato;
        logic        e_err;
    } vec_t;
    vec_t vecs [8];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nombre, act, exp);
        end
    endtask

    task automatic set_ch(input int ch, input logic [7:0] v);
        bus.sig_in[ch*8 +: 8] = v;
    endtask

    task automatic leer(input string nombre, input logic [1:0] dir, input logic [31:0] e_dato,
                        input logic e_ovf, input logic e_err);
        bus.rd_req = 1'b1;
        bus.rd_dir = dir;
        tick();
        bus.rd_req = 1'b0;
        chk({nombre, "_valid"}, 32'(bus.rd_valid), 32'd1);
        chk({nombre, "_dato"}, bus.rd_dato, e_dato);
        chk({nombre, "_ovf"}, 32'(bus.rd_ovf), 32'(e_ovf));
        chk({nombre, "_err"}, 32'(bus.rd_err), 32'(e_err));
        chk({nombre, "_busy"}, 32'(bus.busy), 32'd1);
        bus.rd_ack = 1'b1;
        tick();
        bus.rd_ack = 1'b0;
        chk({nombre, "_valid_off"}, 32'(bus.rd_valid), 32'd0);
    endtask

    task automatic leer4(input string nombre, input logic [3:0] e_dato, input logic e_ovf);
        bus4.rd_req = 1'b1;
        bus4.rd_dir = 2'd0;
        tick();
        bus4.rd_req = 1'b0;
        chk({nombre, "_valid"}, 32'(bus4.rd_valid), 32'd1);
        chk({nombre, "_dato"}, 32'(bus4.rd_dato), 32'(e_dato));
        chk({nombre, "_ovf"}, 32'(bus4.rd_ovf), 32'(e_ovf));
        bus4.rd_ack = 1'b1;
        tick();
        bus4.rd_ack = 1'b0;
        chk({nombre, "_valid_off"}, 32'(bus4.rd_valid), 32'd0);
    endtask

    task automatic limpiar();
        bus.clr    = 1'b1;
        bus.sig_in = '0;
        tick();
        bus.clr = 1'b0;
    endtask

    initial begin
        vecs[0] = '{ch: 1, a: 8'h00, b: 8'hFF, n: 5, en: 1'b1, rd: 2'd1, e_dato: 32'd40, e_err: 1'b0};
        vecs[1] = '{ch: 1, a: 8'h00, b: 8'hFF, n: 5, en: 1'b1, rd: 2'd0, e_dato: 32'd0,  e_err: 1'b0};
        vecs[2] = '{ch: 1, a: 8'h00, b: 8'hFF, n: 5, en: 1'b1, rd: 2'd2, e_dato: 32'd0,  e_err: 1'b0};
        vecs[3] = '{ch: 0, a: 8'h0F, b: 8'hF0, n: 3, en: 1'b1, rd: 2'd0, e_dato: 32'd24, e_err: 1'b0};
        vecs[4] = '{ch: 2, a: 8'h01, b: 8'h00, n: 2, en: 1'b1, rd: 2'd2, e_dato: 32'd2,  e_err: 1'b0};
        vecs[5] = '{ch: 2, a: 8'h01, b: 8'h00, n: 4, en: 1'b0, rd: 2'd2, e_dato: 32'd0,  e_err: 1'b0};
        vecs[6] = '{ch: 1, a: 8'h03, b: 8'h01, n: 7, en: 1'b1, rd: 2'd1, e_dato: 32'd7,  e_err: 1'b0};
        vecs[7] = '{ch: 0, a: 8'hFF, b: 8'h00, n: 2, en: 1'b1, rd: 2'd3, e_dato: 32'd0,  e_err: 1'b1};

        reset_L = 1'b0;
        {bus.en, bus.clr, bus.rd_req, bus.rd_ack} = 4'b1000;
        bus.rd_dir = '0;
        bus.sig_in = '0;
        {bus4.en, bus4.clr, bus4.rd_req, bus4.rd_ack} = 4'b1000;
        bus4.rd_dir = '0;
        bus4.sig_in = '0;
        tick();
        tick();
        chk("rst_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_dato", bus.rd_dato, 32'd0);
        chk("rst_ovf", 32'(bus.rd_ovf), 32'd0);
        chk("rst_err", 32'(bus.rd_err), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        reset_L = 1'b1;

        repeat (10) tick();
        leer("quiet_ch0", 2'd0, 32'd0, 1'b0, 1'b0);

        for (int v = 0; v < 8; v++) begin
            limpiar();
            bus.en = vecs[v].en;
            set_ch(vecs[v].ch, vecs[v].a);
            tick();
            for (int i = 0; i < vecs[v].n; i++) begin
                set_ch(vecs[v].ch, (i % 2 == 0) ? vecs[v].b : vecs[v].a);
                tick();
            end
            bus.en = 1'b1;
            leer($sformatf("vec%0d", v), vecs[v].rd, vecs[v].e_dato, 1'b0, vecs[v].e_err);
        end

        limpiar();
        set_ch(2, 8'h00);
        tick();
        bus.en = 1'b0;
        set_ch(2, 8'h01); tick();
        set_ch(2, 8'h00); tick();
        set_ch(2, 8'h01); tick();
        bus.en = 1'b1;
        set_ch(2, 8'h00); tick();
        set_ch(2, 8'h01); tick();
        leer("en_gate_prev", 2'd2, 32'd2, 1'b0, 1'b0);

        bus4.clr = 1'b1;
        tick();
        bus4.clr = 1'b0;
        bus4.sig_in[7:0] = 8'h0F; tick();
        bus4.sig_in[7:0] = 8'hF0; tick();
        leer4("sat_pre", 4'h8, 1'b0);
        bus4.sig_in[7:0] = 8'h0F; tick();
        bus4.sig_in[7:0] = 8'hF0; tick();
        leer4("sat", 4'hF, 1'b1);
        bus4.clr = 1'b1;
        tick();
        bus4.clr = 1'b0;
        leer4("sat_clr", 4'h0, 1'b0);

        bus.rd_req = 1'b1;
        bus.rd_dir = 2'd3;
        tick();
        bus.rd_dir = 2'd0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hold%0d_valid", i), 32'(bus.rd_valid), 32'd1);
            chk($sformatf("hold%0d_err", i), 32'(bus.rd_err), 32'd1);
            chk($sformatf("hold%0d_dato", i), bus.rd_dato, 32'd0);
            chk($sformatf("hold%0d_busy", i), 32'(bus.busy), 32'd1);
            set_ch(0, (i % 2 == 0) ? 8'hFF : 8'h00);
            tick();
        end
        bus.rd_req = 1'b0;
        bus.rd_ack = 1'b1;
        tick();
        bus.rd_ack = 1'b0;
        chk("hold_release_valid", 32'(bus.rd_valid), 32'd0);
        chk("hold_release_busy", 32'(bus.busy), 32'd0);

        limpiar();
        set_ch(0, 8'h00); tick();
        set_ch(0, 8'hFF); tick();
        leer("pre_clr", 2'd0, 32'd8, 1'b0, 1'b0);
        bus.clr = 1'b1;
        set_ch(0, 8'h00);
        tick();
        bus.clr = 1'b0;
        tick();
        leer("clr_toggle", 2'd0, 32'd0, 1'b0, 1'b0);

        set_ch(0, 8'hFF); tick();
        set_ch(0, 8'h00); tick();
        bus.rd_req = 1'b1;
        bus.rd_dir = 2'd0;
        tick();
        bus.rd_req = 1'b0;
        chk("midrd_valid", 32'(bus.rd_valid), 32'd1);
        chk("midrd_dato", bus.rd_dato, 32'd16);
        #2 reset_L = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.rd_valid), 32'd0);
        chk("async_rst_busy", 32'(bus.busy), 32'd0);
        chk("async_rst_dato", bus.rd_dato, 32'd0);
        tick();
        reset_L = 1'b1;
        tick();
        leer("post_rst", 2'd0, 32'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/contador_transiciones_multicanal.md
Name: contador_transiciones_multicanal

Overview:
Synthesizable, parametrised bank of switching-activity counters, one per monitored channel.
- Each cycle, every channel adds the number of bits of its bus that toggled since the previous sample to its own saturating counter.
- Counters are read back one channel at a time through a request/valid/ack handshake and cleared globally.
- Sits beside the adder datapaths (ripple, logic, lookahead) as the hardware power-estimation monitor; replaces the behavioural tri-state counter memory.

Parameters:
NUM_CH, 3, number of monitored channels (≥1)
SIG_W, 8, width of each monitored bus
CNT_W, 32, counter width per channel
DIR_W, 2, read address width; 2^DIR_W ≥ NUM_CH

Ports:
clk  input  1  sole clock, rising edge
reset_L  input  1  asynchronous active-low reset
en  input  1  count enable; toggles are ignored when 0, but the previous-sample register still updates
sig_in  input  NUM_CH*SIG_W  monitored buses; channel k occupies bits [k*SIG_W +: SIG_W]
clr  input  1  synchronous clear of all counters, overflow flags and primed flags
rd_req  input  1  read request; sampled only in state IDLE
rd_dir  input  DIR_W  channel to read, sampled with rd_req
rd_ack  input  1  consumer accepts rd_dato
rd_valid  output  1  rd_dato/rd_ovf/rd_err are valid
rd_dato  output  CNT_W  counter value snapshot
rd_ovf  output  1  sticky saturation flag of the selected channel
rd_err  output  1  rd_dir ≥ NUM_CH
busy  output  1  read handshake in progress (state VALID)

Behaviour:
- Reset (reset_L=0, asynchronous): all counters = 0, ovf = 0, primed = 0, prev = 0, state IDLE. Outputs rd_valid=0, rd_dato=0, rd_ovf=0, rd_err=0, busy=0.
- Per channel k, each rising edge:
  - prev_k <= sig_k.
  - If primed_k=1 and en=1: cnt_k <= sat(cnt_k + popcount(sig_k ^ prev_k)).
  - primed_k <= 1 on the first edge after reset/clr. That first sample is never counted, so the reset value of prev does not produce spurious toggles.
- Arithmetic: increment is 0..SIG_W, zero-extended to CNT_W.
  - If the sum exceeds 2^CNT_W−1, cnt holds all-ones and ovf_k sets.
  - ovf_k is sticky until clr or reset.
- clr=1: next edge sets all cnt=0, ovf=0, primed=0.
  - clr has priority over counting in the same cycle; that cycle's toggles are lost.
  - clr does not abort a read in progress: the snapshot already in rd_dato is held.
- Read FSM, two states:
  - IDLE: rd_req=1 → snapshot cnt[rd_dir] (value before this edge's increment), ovf[rd_dir], and rd_err. Go to VALID; rd_valid=1 one cycle after the request.
  - If rd_dir ≥ NUM_CH: rd_dato=0, rd_ovf=0, rd_err=1.
  - VALID: outputs held stable while rd_ack=0. rd_ack=1 → IDLE and rd_valid=0 the next cycle.
  - In VALID, rd_req is ignored. Back-to-back reads cost 2 cycles each minimum.
- Counting continues uninterrupted during reads; reads never disturb counters.
- Reset asserted mid-read: immediate return to IDLE, rd_valid=0.

Decomposition:
- Shared package/include: default NUM_CH/SIG_W/CNT_W/DIR_W values, FSM state encodings (IDLE=1'b0, VALID=1'b1), and channel-index constants (RIZADO=0, LOGICO=1, LOOKAHEAD=2) so each adder instance maps to its channel by name.
- One natural sub-module: contador_unos (parametrised popcount of a SIG_W vector, combinational), instantiated NUM_CH times via generate.

Test Plan:
- Reset, drive sig_in constant 0 for 10 cycles with en=1, then read ch0 → rd_valid one cycle after rd_req, rd_dato=0, rd_ovf=0.
- ch1 alternates 8'h00/8'hFF every cycle for 5 toggling cycles after priming, ch0 and ch2 constant → read ch1 = 40, ch0 = 0, ch2 = 0.
- CNT_W=4, ch0 toggling 8'h0F/8'hF0 (8 toggles/cycle) for 3 cycles → rd_dato=4'hF, rd_ovf=1; clr then read → rd_dato=0, rd_ovf=0.
- en=0 during 4 toggling cycles, then en=1 for 2 cycles of 8'h01/8'h00 on ch2 → read ch2 = 2.
- rd_req with rd_dir=3 (NUM_CH=3) → rd_err=1, rd_dato=0. Hold rd_ack=0 for 5 cycles → outputs stable and busy=1; rd_ack=1 → rd_valid=0 next cycle.
- clr and a toggle in the same cycle, plus reset_L pulsed low mid-VALID → counter = 0, and rd_valid drops asynchronously.
